// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: one round per accepted message word, then the
// chaining-value feed-forward. The message schedule is supplied by the caller.
module sha256_round_engine (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] h_in,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] h_out,
  output logic [5:0]   round_idx
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t       state;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] hreg;
  logic [31:0]  sig0, sig1, ch, maj, t1, t2;
  logic [255:0] h_sum;

  always_comb begin
    sig0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    sig1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    ch    = (e & f) ^ (~e & g);
    maj   = (a & b) ^ (a & c) ^ (b & c);
    t1    = h + sig1 + ch + K[round_idx] + w_in;
    t2    = sig0 + maj;
    h_sum = {hreg[255:224] + a, hreg[223:192] + b, hreg[191:160] + c, hreg[159:128] + d,
             hreg[127:96]  + e, hreg[95:64]   + f, hreg[63:32]   + g, hreg[31:0]    + h};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      {a, b, c, d, e, f, g, h} <= '0;
      hreg      <= '0;
      h_out     <= '0;
      round_idx <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      w_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            {a, b, c, d, e, f, g, h} <= h_in;
            hreg      <= h_in;
            round_idx <= '0;
            busy      <= 1'b1;
            w_ready   <= 1'b1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          if (w_valid && w_ready) begin
            {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
            // round_idx parks at 63 through FINAL instead of wrapping
            if (round_idx == 6'd63) begin
              w_ready <= 1'b0;
              state   <= FINAL;
            end else begin
              round_idx <= round_idx + 6'd1;
            end
          end
        end
        FINAL: begin
          hreg  <= h_sum;
          h_out <= h_sum;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
